// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared types and default sizing for the SRAM fetch/data arbiter and the
// pipeline stages that talk to it (fetch stage, MEM stage).
//   arb_state_t : arbiter FSM states (IDLE, ACCESS, DONE)
//   grantee_t   : which requester owns the current SRAM transfer
//   DEFAULT_*   : default SRAM word-address width, access length and
//                 starvation limit, so all stages agree on one value
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grantee_t;

  localparam int DEFAULT_ADDR_W       = 20;
  localparam int DEFAULT_WAIT_CYCLES  = 3;
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_fetch_arbiter_timer.sv
// sram_cycle_timer
// Loadable down-counter that sequences the ACCESS phase of an SRAM transfer.
// Ports:
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset (count returns to 0)
//   load_i      : load loadVal_i into the counter (takes priority)
//   loadVal_i   : value loaded at the start of an access (WAIT_CYCLES-1)
//   en_i        : decrement enable; the counter stops at 0
//   count_o     : current count, cycles remaining after this one
//   last_o      : high when the count is 0, i.e. this is the final cycle
module sram_cycle_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;

  // Count down to zero and hold there; a load restarts the sequence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= loadVal_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == '0);

endmodule

// File: rtl/sram_fetch_arbiter.sv
// sram_fetch_arbiter
// Shares one asynchronous SRAM between instruction fetch and data load/store.
// Data requests win arbitration unless fetch has been passed over
// STARVE_LIMIT times in a row. Every transfer is IDLE -> ACCESS (WAIT_CYCLES
// cycles) -> DONE (one-cycle done pulse, SRAM turnaround). All pad outputs
// come straight from registers.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   if_req/if_addr            : fetch request and byte address
//   if_done/if_rdata          : fetch completion pulse and instruction word
//   mem_req/mem_we/mem_be     : data request, write flag, byte enables
//   mem_addr/mem_wdata        : data byte address and write data
//   mem_done/mem_rdata        : data completion pulse and read data
//   sram_addr/sram_dout       : SRAM word address and write data
//   sram_dout_en              : pad drive enable (writes only)
//   sram_din                  : SRAM read data
//   sram_ce_n/oe_n/we_n/be_n  : active-low SRAM strobes
module sram_fetch_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int WAIT_CYCLES  = DEFAULT_WAIT_CYCLES,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dout,
  output logic              sram_dout_en,
  input  logic [31:0]       sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [STV_W-1:0] STARVE_MAX  = STV_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  grantee_t          grantee_q;
  logic              isWrite_q;
  logic [STV_W-1:0]  starveCnt_q;
  logic [ADDR_W-1:0] sramAddr_q;
  logic [31:0]       sramDout_q;
  logic              sramDoutEn_q;
  logic              sramCeN_q;
  logic              sramOeN_q;
  logic              sramWeN_q;
  logic [3:0]        sramBeN_q;
  logic              ifDone_q;
  logic              memDone_q;
  logic [31:0]       ifRdata_q;
  logic [31:0]       memRdata_q;

  logic              grantFetch;
  logic              grantMem;
  logic              memSkip;
  logic              timerLoad;
  logic              timerEn;
  logic [CNT_W-1:0]  timerCount;
  logic              timerLast;
  logic [ADDR_W-1:0] ifWordAddr;
  logic [ADDR_W-1:0] memWordAddr;
  logic              unusedAddrBits;

  // Byte addresses become SRAM word addresses; bits above the SRAM range
  // and the byte offset are deliberately dropped.
  assign ifWordAddr     = if_addr[ADDR_W+1:2];
  assign memWordAddr    = mem_addr[ADDR_W+1:2];
  assign unusedAddrBits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                            mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  // Arbitration only happens in IDLE: a starved fetch first, then data,
  // then an uncontended fetch.
  always_comb begin
    grantFetch = 1'b0;
    grantMem   = 1'b0;
    if (state_q == IDLE) begin
      if (if_req && (starveCnt_q == STARVE_MAX)) begin
        grantFetch = 1'b1;
      end else if (mem_req) begin
        grantMem = 1'b1;
      end else if (if_req) begin
        grantFetch = 1'b1;
      end
    end
  end

  // A write with no bytes enabled has nothing to do on the SRAM, so it
  // skips ACCESS and completes straight away.
  assign memSkip   = grantMem && mem_we && (mem_be == 4'b0000);
  assign timerLoad = grantFetch || (grantMem && !memSkip);
  assign timerEn   = (state_q == ACCESS);

  // Next-state logic for the transfer sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (memSkip) begin
          state_d = DONE;
        end else if (grantFetch || grantMem) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (timerLast) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sram_cycle_timer #(
    .CNT_W(CNT_W)
  ) uTimer (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (timerLoad),
    .loadVal_i(ACCESS_LOAD),
    .en_i     (timerEn),
    .count_o  (timerCount),
    .last_o   (timerLast)
  );

  // Pad registers, done pulses, read capture and the starvation counter.
  // Strobes are set up on the grant edge so they are valid for the whole
  // ACCESS phase, and released on the edge into DONE so DONE is a clean
  // turnaround cycle. we_n rises one cycle early so address and data are
  // held stable past the end of the write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grantee_q    <= GNT_IF;
      isWrite_q    <= 1'b0;
      starveCnt_q  <= '0;
      sramAddr_q   <= '0;
      sramDout_q   <= '0;
      sramDoutEn_q <= 1'b0;
      sramCeN_q    <= 1'b1;
      sramOeN_q    <= 1'b1;
      sramWeN_q    <= 1'b1;
      sramBeN_q    <= 4'hF;
      ifDone_q     <= 1'b0;
      memDone_q    <= 1'b0;
      ifRdata_q    <= '0;
      memRdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ifDone_q  <= 1'b0;
      memDone_q <= 1'b0;

      if (!if_req || grantFetch) begin
        starveCnt_q <= '0;
      end else if (grantMem && (starveCnt_q != STARVE_MAX)) begin
        starveCnt_q <= starveCnt_q + STV_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (grantFetch) begin
            grantee_q  <= GNT_IF;
            isWrite_q  <= 1'b0;
            sramAddr_q <= ifWordAddr;
            sramCeN_q  <= 1'b0;
            sramOeN_q  <= 1'b0;
            sramBeN_q  <= 4'b0000;
          end else if (grantMem) begin
            grantee_q  <= GNT_MEM;
            isWrite_q  <= mem_we;
            sramAddr_q <= memWordAddr;
            if (mem_we) begin
              sramDout_q <= mem_wdata;
            end
            if (memSkip) begin
              memDone_q <= 1'b1;
            end else if (mem_we) begin
              sramCeN_q    <= 1'b0;
              sramWeN_q    <= 1'b0;
              sramDoutEn_q <= 1'b1;
              sramBeN_q    <= ~mem_be;
            end else begin
              sramCeN_q <= 1'b0;
              sramOeN_q <= 1'b0;
              sramBeN_q <= 4'b0000;
            end
          end
        end
        ACCESS: begin
          if (timerLast) begin
            sramCeN_q    <= 1'b1;
            sramOeN_q    <= 1'b1;
            sramWeN_q    <= 1'b1;
            sramDoutEn_q <= 1'b0;
            sramBeN_q    <= 4'hF;
            if (grantee_q == GNT_IF) begin
              ifDone_q  <= 1'b1;
              ifRdata_q <= sram_din;
            end else begin
              memDone_q <= 1'b1;
              if (!isWrite_q) begin
                memRdata_q <= sram_din;
              end
            end
          end else if (timerCount == CNT_W'(1)) begin
            sramWeN_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign if_done      = ifDone_q;
  assign if_rdata     = ifRdata_q;
  assign mem_done     = memDone_q;
  assign mem_rdata    = memRdata_q;
  assign sram_addr    = sramAddr_q;
  assign sram_dout    = sramDout_q;
  assign sram_dout_en = sramDoutEn_q;
  assign sram_ce_n    = sramCeN_q;
  assign sram_oe_n    = sramOeN_q;
  assign sram_we_n    = sramWeN_q;
  assign sram_be_n    = sramBeN_q;

endmodule

// File: tb/tb_sram_fetch_arbiter.sv
// tb_sram_fetch_arbiter
// Directed bench for sram_fetch_arbiter with default parameters
// (ADDR_W=20, WAIT_CYCLES=3, STARVE_LIMIT=4) and a small behavioural SRAM.
module tb_sram_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [19:0] sram_addr;
  logic [31:0] sram_dout;
  logic        sram_dout_en;
  logic [31:0] sram_din;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  int vectors = 0;
  int miscompares = 0;
  int waited;
  int nDone;
  logic [1:0]  doneOrder [0:5];
  logic [31:0] firstMemRdata;
  logic [31:0] fetchRdata;
  logic [31:0] sramMem [0:127];

  always #5 clk = ~clk;

  sram_fetch_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_rdata    (if_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .sram_addr   (sram_addr),
    .sram_dout   (sram_dout),
    .sram_dout_en(sram_dout_en),
    .sram_din    (sram_din),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_be_n   (sram_be_n)
  );

  // Behavioural SRAM: word i holds A5A5_00ii except word 0x41, which holds
  // an instruction. Contents are reloaded whenever reset is high.
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? sramMem[sram_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) begin
        sramMem[i] <= {16'hA5A5, 8'h00, 8'(i)};
      end
      sramMem[7'h41] <= 32'h2402_0005;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n[b]) begin
          sramMem[sram_addr[6:0]][8*b +: 8] <= sram_dout[8*b +: 8];
        end
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic memReq, input logic memWe,
                               input logic [3:0] memBe, input logic [31:0] memAddr,
                               input logic [31:0] memWdata);
    if_req    = ifReq;
    if_addr   = ifAddr;
    mem_req   = memReq;
    mem_we    = memWe;
    mem_be    = memBe;
    mem_addr  = memAddr;
    mem_wdata = memWdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advances at least one cycle and stops at the first if_done or at limit.
  task automatic waitIfDone(input int limit, output int cycles);
    cycles = 0;
    do begin
      cycle();
      cycles++;
    end while (!if_done && cycles < limit);
    checkOutput("if_done_seen", {31'b0, if_done}, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    cycle();

    // Reset state
    checkOutput("rst_ce_n",   {31'b0, sram_ce_n},    32'h1);
    checkOutput("rst_oe_n",   {31'b0, sram_oe_n},    32'h1);
    checkOutput("rst_we_n",   {31'b0, sram_we_n},    32'h1);
    checkOutput("rst_be_n",   {28'b0, sram_be_n},    32'hF);
    checkOutput("rst_douten", {31'b0, sram_dout_en}, 32'h0);
    checkOutput("rst_addr",   {12'b0, sram_addr},    32'h0);
    checkOutput("rst_dout",   sram_dout,             32'h0);
    checkOutput("rst_dones",  {30'b0, if_done, mem_done}, 32'h0);
    checkOutput("rst_rdata",  if_rdata | mem_rdata,  32'h0);
    rst = 1'b0;

    // Single fetch from 0x104: word 0x41, three read cycles, done on the 4th
    $display("[TB] single fetch");
    applyStimulus(1'b1, 32'h0000_0104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkOutput("fetch_strobes", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 32'h2);
      checkOutput("fetch_be_n",    {28'b0, sram_be_n}, 32'h0);
      checkOutput("fetch_addr",    {12'b0, sram_addr}, 32'h41);
      checkOutput("fetch_nodone",  {30'b0, if_done, mem_done}, 32'h0);
    end
    cycle();
    checkOutput("fetch_done",   {30'b0, if_done, mem_done}, 32'h2);
    checkOutput("fetch_rdata",  if_rdata, 32'h2402_0005);
    checkOutput("fetch_turn",   {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    checkOutput("fetch_pulse1", {30'b0, if_done, mem_done}, 32'h0);

    // Partial write: be 0011 to 0x10, we_n low only in the first two cycles
    $display("[TB] partial write");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkOutput("wr_ce_douten", {30'b0, sram_ce_n, sram_dout_en}, 32'h1);
      checkOutput("wr_we_n",      {31'b0, sram_we_n}, (i == 3) ? 32'h1 : 32'h0);
      checkOutput("wr_be_n",      {28'b0, sram_be_n}, 32'hC);
      checkOutput("wr_oe_n",      {31'b0, sram_oe_n}, 32'h1);
    end
    checkOutput("wr_addr", {12'b0, sram_addr}, 32'h4);
    checkOutput("wr_dout", sram_dout, 32'hDEAD_BEEF);
    cycle();
    checkOutput("wr_done", {30'b0, if_done, mem_done}, 32'h1);
    checkOutput("wr_turn", {29'b0, sram_ce_n, sram_we_n, sram_dout_en}, 32'h6);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    checkOutput("wr_pulse1", {30'b0, if_done, mem_done}, 32'h0);
    checkOutput("wr_sram_word", sramMem[4], 32'hA5A5_BEEF);

    // Write with no byte enables: done on the next cycle, no strobes at all
    $display("[TB] empty write");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h0000_0020, 32'h1234_5678);
    cycle();
    checkOutput("be0_done",    {30'b0, if_done, mem_done}, 32'h1);
    checkOutput("be0_strobes", {30'b0, sram_ce_n, sram_we_n}, 32'h3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    checkOutput("be0_pulse1",  {30'b0, if_done, mem_done}, 32'h0);
    checkOutput("be0_strobes2", {30'b0, sram_ce_n, sram_we_n}, 32'h3);

    // Contention: fetch 0x8 (A5A5_0002) versus data read 0xC (A5A5_0003)
    $display("[TB] starvation guard");
    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 1'b0, 4'hF, 32'h0000_000C, 32'h0);
    nDone = 0;
    firstMemRdata = 32'h0;
    fetchRdata = 32'h0;
    for (int i = 0; i < 6; i++) doneOrder[i] = 2'b00;
    for (int c = 0; c < 40 && nDone < 6; c++) begin
      cycle();
      if (if_done || mem_done) begin
        doneOrder[nDone] = {if_done, mem_done};
        if (mem_done && nDone == 0) firstMemRdata = mem_rdata;
        if (if_done) fetchRdata = if_rdata;
        nDone++;
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("starve_count", nDone, 32'd6);
    checkOutput("grant0", {30'b0, doneOrder[0]}, 32'h1);
    checkOutput("grant1", {30'b0, doneOrder[1]}, 32'h1);
    checkOutput("grant2", {30'b0, doneOrder[2]}, 32'h1);
    checkOutput("grant3", {30'b0, doneOrder[3]}, 32'h1);
    checkOutput("grant4", {30'b0, doneOrder[4]}, 32'h2);
    checkOutput("grant5", {30'b0, doneOrder[5]}, 32'h1);
    checkOutput("starve_mem_rdata", firstMemRdata, 32'hA5A5_0003);
    checkOutput("starve_if_rdata",  fetchRdata,    32'hA5A5_0002);
    cycle();

    // Reset during the second ACCESS cycle of a fetch
    $display("[TB] reset mid-access");
    applyStimulus(1'b1, 32'h0000_0104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    checkOutput("rstmid_ce1", {31'b0, sram_ce_n}, 32'h0);
    cycle();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    checkOutput("rstmid_strobes", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 32'hE);
    checkOutput("rstmid_be_n",    {28'b0, sram_be_n}, 32'hF);
    checkOutput("rstmid_done",    {30'b0, if_done, mem_done}, 32'h0);
    checkOutput("rstmid_rdata",   if_rdata, 32'h0);
    rst = 1'b0;
    cycle();
    checkOutput("rstmid_nodone",  {30'b0, if_done, mem_done}, 32'h0);
    applyStimulus(1'b1, 32'h0000_0004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitIfDone(10, waited);
    checkOutput("rstmid_latency", waited, 32'd4);
    checkOutput("rstmid_rdata2",  if_rdata, 32'hA5A5_0001);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();

    // Back-to-back fetches with req held: 0x0, 0x4, 0x8
    $display("[TB] back-to-back fetch");
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitIfDone(10, waited);
    checkOutput("b2b_lat0",   waited, 32'd4);
    checkOutput("b2b_rdata0", if_rdata, 32'hA5A5_0000);
    if_addr = 32'h0000_0004;
    waitIfDone(10, waited);
    checkOutput("b2b_gap1",   waited, 32'd5);
    checkOutput("b2b_rdata1", if_rdata, 32'hA5A5_0001);
    if_addr = 32'h0000_0008;
    waitIfDone(10, waited);
    checkOutput("b2b_gap2",   waited, 32'd5);
    checkOutput("b2b_rdata2", if_rdata, 32'hA5A5_0002);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    checkOutput("b2b_pulse1", {30'b0, if_done, mem_done}, 32'h0);
    checkOutput("b2b_hold",   if_rdata, 32'hA5A5_0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
